// File: rtl/nibble_rx_pkg.sv
// Shared constants and helpers for the nibble receive path.
package nibble_rx_pkg;

  localparam int NIBBLE_W = 4;

  // Ceiling log2, evaluated at elaboration for pointer/level widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Word buffer: registered storage, pointers one bit wider than the address
// so full and empty are distinguishable without a separate count.
module word_fifo
  import nibble_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; the caller only raises push when there is room
  // (or when the head is leaving in the same cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; entry 0 is cleared on reset so the head reads zero.
  // A push into a full FIFO with a simultaneous pop overwrites the slot
  // being consumed this cycle, which is safe because head is read first.
  always_ff @(posedge clk) begin
    if (rst)       mem[0]               <= '0;
    else if (push) mem[wr_ptr[AW-1:0]]  <= push_data;
  end

endmodule

// File: rtl/nibble_deserializer.sv
// Collects 4-bit nibbles into words (first nibble in the LSBs), buffers
// completed words, and flags any word that could not be stored.
module nibble_deserializer
  import nibble_rx_pkg::*;
#(
  parameter int NIBBLES_PER_WORD = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NIBBLE_W-1:0]                  data_bus,
  input  logic                                 valid,
  input  logic                                 align,
  output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0] word_data,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic                                 overflow,
  input  logic                                 clear_overflow,
  output logic [clog2(FIFO_DEPTH):0]           fifo_level
);

  localparam int WORD_W = NIBBLE_W * NIBBLES_PER_WORD;
  localparam int IDX_W  = clog2(NIBBLES_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES_PER_WORD - 1);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] partial;

  logic [IDX_W-1:0]  idx_eff;
  logic [WORD_W-1:0] assembled;
  logic              word_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Current nibble merged into the partial word; align restarts at nibble 0.
  always_comb begin
    idx_eff   = align ? '0 : idx;
    assembled = align ? '0 : partial;
    assembled[int'(idx_eff)*NIBBLE_W +: NIBBLE_W] = data_bus;
    word_done = valid && (idx_eff == IDX_LAST);
  end

  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign push_ok    = word_done && (!fifo_full || pop);
  assign drop       = word_done && fifo_full && !pop;

  // Assembly counter and partial word; wraps normally even on a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      partial <= '0;
    end else if (valid) begin
      idx     <= word_done ? '0 : idx_eff + IDX_W'(1);
      partial <= word_done ? '0 : assembled;
    end else if (align) begin
      idx     <= '0;
      partial <= '0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)                 overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (assembled),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (word_data)
  );

endmodule
